snake_state: RTL

Holds the snake's segment coordinates, heading, length and apple position, and answers per-cell occupancy queries. It is the responding end of the frame scan interface: `frame_tracker` drives `x`/`y` and samples `head`/`body`/`apple`/`border` from this block to build `obj_code`. Game-tick logic drives `step`, `dir`, `grow` and `apple_load`.

---
 rtl/snake_state.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/snake_state.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : snake_state                                                  |
// | Description : Snake game state. Holds segment coordinates, heading,        |
// |               length and apple position; advances the snake on step,       |
// |               detects collisions, and answers zero-latency per-cell        |
// |               occupancy queries for the frame scanner.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk          in   system clock, rising edge                              |
// |   rst          in   asynchronous active-high reset                         |
// |   x, y         in   query cell (4-bit column / row)                        |
// |   step         in   advance the snake one cell                             |
// |   dir          in   requested heading: 00 +x, 01 -x, 10 -y, 11 +y          |
// |   grow         in   lengthen the snake on the next step                    |
// |   apple_load   in   load apple position from apple_x / apple_y             |
// |   head         out  query cell is segment 0                               |
// |   body         out  query cell is one of segments 1..length-1             |
// |   apple        out  query cell is the apple                                |
// |   border       out  query cell lies on the grid edge                       |
// |   length       out  current segment count                                  |
// |   dead         out  sticky collision flag                                  |
// | Build option                                                               |
// |   SNAKE_WRAP_EN  defined: heads leaving the playfield reappear on the      |
// |                  opposite side and only self-collision is fatal.           |
// +----------------------------------------------------------------------------+
module snake_state #(
    parameter  int MAX_LEN = 8,
    parameter  int GRID_W  = 16,
    parameter  int GRID_H  = 12,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       x,
    input  logic [3:0]       y,
    input  logic             step,
    input  logic [1:0]       dir,
    input  logic             grow,
    input  logic             apple_load,
    input  logic [3:0]       apple_x,
    input  logic [3:0]       apple_y,
    output logic             head,
    output logic             body,
    output logic             apple,
    output logic             border,
    output logic [LEN_W-1:0] length,
    output logic             dead
);

    localparam logic [3:0] c_X_MAX = 4'(GRID_W - 1);
    localparam logic [3:0] c_Y_MAX = 4'(GRID_H - 1);

    localparam logic [0:0] c_ST_ALIVE = 1'b0;
    localparam logic [0:0] c_ST_DEAD  = 1'b1;

    logic [7:0]       r_seg [0:MAX_LEN-1];
    logic [LEN_W-1:0] r_len;
    logic [1:0]       r_heading;
    logic             r_grow_pending;
    logic [3:0]       r_apple_x;
    logic [3:0]       r_apple_y;
    logic [0:0]       r_state;
    logic             r_dead;

    logic [31:0]        w_len32;
    logic               w_reverse;
    logic [1:0]         w_heading_nxt;
    logic [3:0]         w_raw_x;
    logic [3:0]         w_raw_y;
    logic [3:0]         w_next_x;
    logic [3:0]         w_next_y;
    logic [7:0]         w_next_head;
    logic               w_wall_hit;
    logic               w_growing;
    logic               w_collide;
    logic [MAX_LEN-1:0] w_self_hit;
    logic [MAX_LEN-1:0] w_body_hit;
    logic [7:0]         w_query;
    logic               w_on_border;
    logic               w_on_head;
    logic               w_on_body;
    logic               w_on_apple;

    assign w_len32 = 32'(r_len);

    // Opposite headings differ only in bit 0 within the same axis pair.
    assign w_reverse     = (dir == {r_heading[1], ~r_heading[0]});
    assign w_heading_nxt = w_reverse ? r_heading : dir;

    always_comb begin
        w_raw_x = r_seg[0][7:4];
        w_raw_y = r_seg[0][3:0];
        case (w_heading_nxt)
            2'b00:   w_raw_x = r_seg[0][7:4] + 4'd1;
            2'b01:   w_raw_x = r_seg[0][7:4] - 4'd1;
            2'b10:   w_raw_y = r_seg[0][3:0] - 4'd1;
            default: w_raw_y = r_seg[0][3:0] + 4'd1;
        endcase
    end

`ifdef SNAKE_WRAP_EN
    // Border cells are never occupied: land on the first interior cell of
    // the opposite side instead.
    assign w_next_x   = (w_raw_x == c_X_MAX) ? 4'd1 :
                        (w_raw_x == 4'd0)    ? 4'(GRID_W - 2) : w_raw_x;
    assign w_next_y   = (w_raw_y == c_Y_MAX) ? 4'd1 :
                        (w_raw_y == 4'd0)    ? 4'(GRID_H - 2) : w_raw_y;
    assign w_wall_hit = 1'b0;
`else
    assign w_next_x   = w_raw_x;
    assign w_next_y   = w_raw_y;
    assign w_wall_hit = (w_raw_x == 4'd0) || (w_raw_x == c_X_MAX) ||
                        (w_raw_y == 4'd0) || (w_raw_y == c_Y_MAX);
`endif

    assign w_next_head = {w_next_x, w_next_y};
    assign w_growing   = (r_grow_pending || grow) && (w_len32 < MAX_LEN);

    assign w_query = {x, y};

    generate
        for (genvar i = 0; i < MAX_LEN; i++) begin : g_seg
            // The tail vacates its cell on a normal step, so it only counts
            // as an obstacle when the snake is growing.
            assign w_self_hit[i] = (r_seg[i] == w_next_head) &&
                                   (((i + 1) < w_len32) || (w_growing && (i < w_len32)));
            if (i == 0) begin : g_head
                assign w_body_hit[i] = 1'b0;
            end else begin : g_tail
                // Entries past the live length hold stale coordinates.
                assign w_body_hit[i] = (r_seg[i] == w_query) && (i < w_len32);
            end
        end
    endgenerate

    assign w_collide = (|w_self_hit) || w_wall_hit;

    assign w_on_border = (x == 4'd0) || (x == c_X_MAX) || (y == 4'd0) || (y == c_Y_MAX);
    assign w_on_head   = (r_seg[0] == w_query);
    assign w_on_body   = |w_body_hit;
    assign w_on_apple  = ({r_apple_x, r_apple_y} == w_query);

    assign border = w_on_border;
    assign head   = !w_on_border && w_on_head;
    assign body   = !w_on_border && !w_on_head && w_on_body;
    assign apple  = !w_on_border && !w_on_head && !w_on_body && w_on_apple;
    assign length = r_len;
    assign dead   = r_dead;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg[i] <= 8'h00;
            end
            r_seg[0]       <= {4'd4, 4'd4};
            r_seg[1]       <= {4'd3, 4'd4};
            r_len          <= LEN_W'(2);
            r_heading      <= 2'b00;
            r_grow_pending <= 1'b0;
            r_apple_x      <= 4'd8;
            r_apple_y      <= 4'd4;
            r_state        <= c_ST_ALIVE;
            r_dead         <= 1'b0;
        end else begin
            if (apple_load) begin
                r_apple_x <= apple_x;
                r_apple_y <= apple_y;
            end
            case (r_state)
                c_ST_ALIVE: begin
                    if (step) begin
                        r_heading <= w_heading_nxt;
                        if (w_collide) begin
                            r_state <= c_ST_DEAD;
                            r_dead  <= 1'b1;
                        end else begin
                            for (int i = 1; i < MAX_LEN; i++) begin
                                r_seg[i] <= r_seg[i-1];
                            end
                            r_seg[0]       <= w_next_head;
                            r_grow_pending <= 1'b0;
                            if (w_growing) begin
                                r_len <= r_len + 1'b1;
                            end
                        end
                    end else if (grow) begin
                        r_grow_pending <= 1'b1;
                    end
                end
                default: begin
                    // Frozen until reset; only the apple register moves.
                end
            endcase
        end
    end

endmodule
`default_nettype wire
